// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR widths, control state type and filter coefficient constants.
package fir_pkg;
    localparam int FIR_DATA_W = 32;
    localparam int FIR_TAPS   = 4;
    typedef enum logic {STREAM, FLUSH} state_e;
    // IEEE-754 single 0.25 on every tap: a 4-point moving average.
    localparam logic [FIR_TAPS-1:0][31:0] FIR_COEF = {FIR_TAPS{32'h3E80_0000}};
endpackage

// File: rtl/fir_tap_shreg.sv
// fir_tap_shreg: TAPS x DATA_W window shift register; slot 0 takes the new word.
// A clear together with a shift keeps only the incoming word, starting a fresh window.
module fir_tap_shreg import fir_pkg::*; #(
    parameter int DATA_W = FIR_DATA_W,
    parameter int TAPS   = FIR_TAPS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift_en_i,
    input  logic                     clear_i,
    input  logic                     zero_ins_i,
    input  logic [DATA_W-1:0]        din_i,
    output logic [TAPS*DATA_W-1:0]   taps_o
);
    logic [TAPS*DATA_W-1:0] taps_q, taps_d;

    always_comb begin
        taps_d = taps_q;
        if (shift_en_i)
            taps_d = {clear_i ? {(TAPS-1)*DATA_W{1'b0}} : taps_q[(TAPS-1)*DATA_W-1:0],
                      zero_ins_i ? {DATA_W{1'b0}} : din_i};
        else if (clear_i)
            taps_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) taps_q <= '0;
        else        taps_q <= taps_d;
    end

    assign taps_o = taps_q;
endmodule

// File: rtl/fir_sample_window.sv
// fir_sample_window: sliding TAPS-sample window with zero-padded startup for the FIR MAC stage.
// Optional FIR_WINDOW_FLUSH_EN: after in_last, shift TAPS-1 zero words out before the next signal.
module fir_sample_window import fir_pkg::*; #(
    parameter int DATA_W = FIR_DATA_W,
    parameter int TAPS   = FIR_TAPS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_last,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [TAPS*DATA_W-1:0] win_data,
    output logic                   win_first,
    output logic                   win_last
);
    localparam int CW = $clog2(TAPS);
    localparam logic [CW-1:0] CNT_MAX = CW'(TAPS-1);

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_base;
    logic valid_q, valid_d, first_q, first_d, last_q, last_d;
    logic in_fire, out_fire, clr, shift, zero_ins;
`ifdef FIR_WINDOW_FLUSH_EN
    logic [CW-1:0] fcnt_q, fcnt_d;
`endif

    assign in_ready  = (state_q == STREAM) && (!valid_q || win_ready);
    assign win_valid = valid_q;
    assign win_first = first_q;
    assign win_last  = last_q;

    always_comb begin
        in_fire  = in_valid && in_ready;
        out_fire = valid_q && win_ready;
        clr      = out_fire && last_q;
        // Sending the last window restarts the count, even for a sample accepted in the same cycle.
        cnt_base = clr ? '0 : cnt_q;
        shift    = in_fire;
        zero_ins = 1'b0;
        state_d  = clr ? STREAM : state_q;
        cnt_d    = cnt_base;
        valid_d  = valid_q && !win_ready;
        first_d  = first_q;
        last_d   = last_q;
`ifdef FIR_WINDOW_FLUSH_EN
        fcnt_d   = fcnt_q;
`endif
        if (in_fire) begin
            valid_d = 1'b1;
            first_d = (cnt_base == '0);
            cnt_d   = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;
`ifdef FIR_WINDOW_FLUSH_EN
            last_d  = 1'b0;
            state_d = in_last ? FLUSH : STREAM;
            fcnt_d  = CNT_MAX;
`else
            last_d  = in_last;
`endif
        end
`ifdef FIR_WINDOW_FLUSH_EN
        if (state_q == FLUSH && out_fire && !last_q) begin
            shift    = 1'b1;
            zero_ins = 1'b1;
            valid_d  = 1'b1;
            first_d  = 1'b0;
            last_d   = (fcnt_q == CW'(1));
            fcnt_d   = fcnt_q - 1'b1;
            cnt_d    = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STREAM;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef FIR_WINDOW_FLUSH_EN
            fcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
`ifdef FIR_WINDOW_FLUSH_EN
            fcnt_q  <= fcnt_d;
`endif
        end
    end

    fir_tap_shreg #(.DATA_W(DATA_W), .TAPS(TAPS)) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en_i (shift),
        .clear_i    (clr),
        .zero_ins_i (zero_ins),
        .din_i      (in_data),
        .taps_o     (win_data)
    );
endmodule

// File: tb/tb_fir_sample_window.sv
// tb_fir_sample_window: scoreboard bench; a signal-history model predicts every window.
module tb_fir_sample_window;
    localparam int DW = 32;
    localparam int T  = 4;
    localparam int WW = DW * T;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, win_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, win_valid, win_first, win_last;
    logic [WW-1:0] win_data;

    always #5 clk = ~clk;

    fir_sample_window #(.DATA_W(DW), .TAPS(T)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .win_valid(win_valid), .win_ready(win_ready),
        .win_data(win_data), .win_first(win_first), .win_last(win_last)
    );

    typedef struct { logic [WW-1:0] data; logic first; logic last; int avail; } exp_t;
    exp_t sb[$];
    logic [DW-1:0] hist[$];
    int sig_len = 0, chk_n = 0, err_n = 0, cyc = 0;
    logic held_v = 1'b0, held_f, held_l;
    logic [WW-1:0] held_d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        chk_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] model_win();
        logic [WW-1:0] w;
        for (int k = 0; k < T; k++) w[k*DW +: DW] = (k < hist.size()) ? hist[k] : '0;
        return w;
    endfunction

    task automatic push_win(input logic f, input logic l);
        exp_t e;
        e.data = model_win(); e.first = f; e.last = l; e.avail = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic add_word(input logic [DW-1:0] d);
        hist.push_front(d);
        if (hist.size() > T) void'(hist.pop_back());
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic f;
        if (!rst_n) begin
            sb.delete(); hist.delete(); sig_len = 0; held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", win_valid, 1'b1);
                check("hold_data", win_data, held_d);
                check("hold_flags", {win_first, win_last}, {held_f, held_l});
            end
            if (sb.size() == 0) check("idle_valid", win_valid, 1'b0);
            else if (sb[0].avail <= cyc) check("window_latency", win_valid, 1'b1);
            if (win_valid && win_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("win_data", win_data, e.data);
                check("win_first", win_first, e.first);
                check("win_last", win_last, e.last);
            end
`ifdef FIR_WINDOW_FLUSH_EN
            check("in_ready_bp", in_ready && win_valid && !win_ready, 1'b0);
`else
            check("in_ready_rule", in_ready, !win_valid || win_ready);
`endif
            held_v = win_valid && !win_ready;
            held_d = win_data; held_f = win_first; held_l = win_last;
            if (in_valid && in_ready) begin
                add_word(in_data);
                f = (sig_len == 0);
                sig_len++;
`ifdef FIR_WINDOW_FLUSH_EN
                push_win(f, 1'b0);
                if (in_last) begin
                    for (int j = 1; j < T; j++) begin
                        add_word('0);
                        push_win(1'b0, j == T - 1);
                    end
                end
`else
                push_win(f, in_last);
`endif
                if (in_last) begin hist.delete(); sig_len = 0; end
            end
        end
    end

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        logic ok = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); ok = in_ready;
            cycle();
        end
        check("send_accept", ok, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, win_valid, 1'b0);
        check({tag, "_first"}, win_first, 1'b0);
        check({tag, "_last"}, win_last, 1'b0);
        check({tag, "_data"}, win_data, '0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        int acc = 0;
        win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); check_reset_outputs("rst");
        cycle();
        for (int i = 1; i <= 5; i++) send(DW'(i), 1'b0);
        win_ready = 1'b0; in_valid = 1'b1; in_data = 6;
        repeat (3) begin @(negedge clk); check("bp_in_ready", in_ready, 1'b0); end
        cycle();
        win_ready = 1'b1;
        send(6, 1'b0);
        send(7, 1'b1);
        send(9, 1'b0);
        send(10, 1'b0);
        send(11, 1'b0);
        win_ready = 1'b0; rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        @(negedge clk); check_reset_outputs("midrst");
        cycle();
        win_ready = 1'b1;
        send(8, 1'b0);
        send(20, 1'b1);
        send(21, 1'b1);
        for (int c = 0; c < 20000 && acc < 1000; c++) begin
            in_valid = 1'($urandom % 2); in_data = $urandom;
            in_last = (($urandom % 16) == 0); win_ready = 1'($urandom % 2);
            @(negedge clk); if (in_valid && in_ready) acc++;
            cycle();
        end
        check("random_accepted", acc, 1000);
        in_valid = 1'b0; in_last = 1'b0; win_ready = 1'b1;
        for (int c = 0; c < 200 && sb.size() > 0; c++) cycle();
        check("drain_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
        $finish;
    end
endmodule
